// File: rtl/cache_miss_ctrl_if.sv
// Memory-side bus of the cache miss controller: one request channel
// (writeback or refill read) and one refill data return.
// The controller owns the request payload and listens for ready/response.
interface cache_miss_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 512
);
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_req_we_o;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic [LINE_WIDTH-1:0] mem_wdata_o;
    logic                  mem_rsp_valid_i;
    logic [LINE_WIDTH-1:0] mem_rsp_data_i;

    // Controller side
    modport master (
        output mem_req_valid_o,
        output mem_req_we_o,
        output mem_req_addr_o,
        output mem_wdata_o,
        input  mem_req_ready_i,
        input  mem_rsp_valid_i,
        input  mem_rsp_data_i
    );

    // Memory side
    modport slave (
        input  mem_req_valid_o,
        input  mem_req_we_o,
        input  mem_req_addr_o,
        input  mem_wdata_o,
        output mem_req_ready_i,
        output mem_rsp_valid_i,
        output mem_rsp_data_i
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Two-way cache miss controller. Accepts one CPU request at a time,
// consults the tag compare result, and on a miss writes back a dirty
// victim line before refilling the requested line from memory.
// All outputs are registered except the replacement-age update strobes,
// which must coincide with the LOOKUP cycle in which the tag result arrives.
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 512,
    parameter int SETS       = 128,
    localparam int SET_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WIDTH / 8)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // CPU request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,

    // Tag compare result for the latched address
    input  logic                  lookup_hit_i,
    input  logic                  lookup_way_i,

    // LRU victim selection and its contents
    input  logic                  victim_way_i,
    input  logic                  victim_dirty_i,
    input  logic [ADDR_WIDTH-1:0] victim_addr_i,
    input  logic [LINE_WIDTH-1:0] victim_line_i,

    // Replacement-age update
    output logic                  lru_hit_o,
    output logic                  lru_miss_o,
    output logic                  lru_way_o,

    // Memory bus
    cache_miss_ctrl_if.master     mem,

    // Line write into the data/tag array
    output logic                  fill_we_o,
    output logic                  fill_way_o,
    output logic [SET_W-1:0]      fill_set_o,
    output logic [LINE_WIDTH-1:0] fill_line_o,

    // Response and statistics
    output logic                  resp_valid_o,
    output logic                  resp_hit_o,
    output logic [15:0]           hit_cnt_o,
    output logic [15:0]           miss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

    // Clears the byte-offset bits to form a line-aligned refill address.
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    victim_way_reg;
    logic                    mem_valid_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [LINE_WIDTH-1:0]   mem_wdata_reg;
    logic [15:0]             hit_cnt_reg;
    logic [15:0]             miss_cnt_reg;
    logic [ADDR_WIDTH-1:0]   line_addr;

    assign line_addr = addr_reg & ~OFF_MASK;

    assign mem.mem_req_valid_o = mem_valid_reg;
    assign mem.mem_req_we_o    = mem_we_reg;
    assign mem.mem_req_addr_o  = mem_addr_reg;
    assign mem.mem_wdata_o     = mem_wdata_reg;

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;

    // The age update must land in the same cycle the tag result is valid,
    // so these strobes are decoded directly from LOOKUP and the inputs.
    assign lru_hit_o  = (state_reg == LOOKUP) &&  lookup_hit_i;
    assign lru_miss_o = (state_reg == LOOKUP) && !lookup_hit_i;
    assign lru_way_o  = (state_reg == LOOKUP) ?
                        (lookup_hit_i ? lookup_way_i : victim_way_i) : 1'b0;

    // Controller FSM with registered outputs set on entry to each state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            req_ready_o    <= 1'b1;
            addr_reg       <= '0;
            victim_way_reg <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            fill_we_o      <= 1'b0;
            fill_way_o     <= 1'b0;
            fill_set_o     <= '0;
            fill_line_o    <= '0;
            resp_valid_o   <= 1'b0;
            resp_hit_o     <= 1'b0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            // Single-cycle pulses fall back unless re-armed below.
            fill_we_o    <= 1'b0;
            resp_valid_o <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_reg    <= req_addr_i;
                        req_ready_o <= 1'b0;
                        state_reg   <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (lookup_hit_i) begin
                        if (hit_cnt_reg != 16'hFFFF) begin
                            hit_cnt_reg <= hit_cnt_reg + 16'd1;
                        end
                        resp_valid_o <= 1'b1;
                        resp_hit_o   <= 1'b1;
                        state_reg    <= RESP;
                    end else begin
                        if (miss_cnt_reg != 16'hFFFF) begin
                            miss_cnt_reg <= miss_cnt_reg + 16'd1;
                        end
                        victim_way_reg <= victim_way_i;
                        mem_valid_reg  <= 1'b1;
                        if (victim_dirty_i) begin
                            // Victim address and line are captured here so
                            // the write payload stays stable across stalls.
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= victim_addr_i;
                            mem_wdata_reg <= victim_line_i;
                            state_reg     <= WB_REQ;
                        end else begin
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= line_addr;
                            state_reg    <= FILL_REQ;
                        end
                    end
                end

                WB_REQ: begin
                    // Writes are posted: no response is awaited.
                    if (mem.mem_req_ready_i) begin
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= line_addr;
                        state_reg    <= FILL_REQ;
                    end
                end

                FILL_REQ: begin
                    if (mem.mem_req_ready_i) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= FILL_WAIT;
                    end
                end

                FILL_WAIT: begin
                    if (mem.mem_rsp_valid_i) begin
                        fill_we_o    <= 1'b1;
                        fill_way_o   <= victim_way_reg;
                        fill_set_o   <= addr_reg[OFF_W+SET_W-1:OFF_W];
                        fill_line_o  <= mem.mem_rsp_data_i;
                        resp_valid_o <= 1'b1;
                        resp_hit_o   <= 1'b0;
                        state_reg    <= RESP;
                    end
                end

                RESP: begin
                    resp_hit_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    state_reg   <= IDLE;
                end

                default: begin
                    req_ready_o   <= 1'b1;
                    mem_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hit, clean miss, dirty miss with a
// stalled writeback, spurious responses, back-to-back hits, mid-transaction
// reset and counter saturation. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_cache_miss_ctrl;
    localparam int AW = 32;
    localparam int LW = 512;
    localparam int SW = 7;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          lookup_hit_i;
    logic          lookup_way_i;
    logic          victim_way_i;
    logic          victim_dirty_i;
    logic [AW-1:0] victim_addr_i;
    logic [LW-1:0] victim_line_i;
    logic          lru_hit_o;
    logic          lru_miss_o;
    logic          lru_way_o;
    logic          fill_we_o;
    logic          fill_way_o;
    logic [SW-1:0] fill_set_o;
    logic [LW-1:0] fill_line_o;
    logic          resp_valid_o;
    logic          resp_hit_o;
    logic [15:0]   hit_cnt_o;
    logic [15:0]   miss_cnt_o;

    cache_miss_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mif ();

    cache_miss_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .SETS(128)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .lookup_hit_i   (lookup_hit_i),
        .lookup_way_i   (lookup_way_i),
        .victim_way_i   (victim_way_i),
        .victim_dirty_i (victim_dirty_i),
        .victim_addr_i  (victim_addr_i),
        .victim_line_i  (victim_line_i),
        .lru_hit_o      (lru_hit_o),
        .lru_miss_o     (lru_miss_o),
        .lru_way_o      (lru_way_o),
        .mem            (mif),
        .fill_we_o      (fill_we_o),
        .fill_way_o     (fill_way_o),
        .fill_set_o     (fill_set_o),
        .fill_line_o    (fill_line_o),
        .resp_valid_o   (resp_valid_o),
        .resp_hit_o     (resp_hit_o),
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          hs_cnt  = 0;
    logic        hs_we;
    logic [AW-1:0] hs_addr;
    logic [15:0] exp_hit  = 16'd0;
    logic [15:0] exp_miss = 16'd0;
    logic [LW-1:0] line_a, line_b, line_c;

    // Records every accepted memory request.
    always @(posedge clk_i) begin
        if (mif.mem_req_valid_o && mif.mem_req_ready_i) begin
            hs_cnt  = hs_cnt + 1;
            hs_we   = mif.mem_req_we_o;
            hs_addr = mif.mem_req_addr_o;
        end
    end

    // Guard against a stuck simulation.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req_valid_i         = 1'b0;
        req_addr_i          = '0;
        lookup_hit_i        = 1'b0;
        lookup_way_i        = 1'b0;
        victim_way_i        = 1'b0;
        victim_dirty_i      = 1'b0;
        victim_addr_i       = '0;
        victim_line_i       = '0;
        mif.mem_req_ready_i = 1'b0;
        mif.mem_rsp_valid_i = 1'b0;
        mif.mem_rsp_data_i  = '0;
    endtask

    // Stimulus only: a clean miss served by zero-wait memory, ending in IDLE.
    task automatic run_clean_miss(input logic [AW-1:0] addr);
        req_valid_i = 1'b1; req_addr_i = addr; lookup_hit_i = 1'b0;
        victim_dirty_i = 1'b0; victim_way_i = 1'b0;
        mif.mem_req_ready_i = 1'b1;
        tick();                                 // LOOKUP
        req_valid_i = 1'b0;
        tick();                                 // FILL_REQ
        tick();                                 // FILL_WAIT
        mif.mem_req_ready_i = 1'b0; mif.mem_rsp_valid_i = 1'b1;
        tick();                                 // RESP
        mif.mem_rsp_valid_i = 1'b0;
        tick();                                 // IDLE
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        tick(); tick();
        vec_cnt++; if (req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b exp 1", req_ready_o); end
        vec_cnt++; if (resp_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid_o); end
        vec_cnt++; if (hit_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL reset_counters got %h/%h exp 0/0", hit_cnt_o, miss_cnt_o); end
        vec_cnt++; if (mif.mem_req_valid_o !== 1'b0 || fill_we_o !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_fill got %b/%b exp 0/0", mif.mem_req_valid_o, fill_we_o); end
        vec_cnt++; if (lru_hit_o !== 1'b0 || lru_miss_o !== 1'b0) begin err_cnt++; $display("FAIL reset_lru got %b/%b exp 0/0", lru_hit_o, lru_miss_o); end
        rst_i = 1'b0;
        tick();
        vec_cnt++; if (req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL post_reset_ready got %b exp 1", req_ready_o); end
        $display("reset: done");
    endtask

    task automatic test_hit();
        req_valid_i = 1'b1; req_addr_i = 32'h1040; lookup_hit_i = 1'b1; lookup_way_i = 1'b1;
        vec_cnt++; if (req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL hit_accept_ready got %b exp 1", req_ready_o); end
        tick();                                 // cycle 2: LOOKUP
        req_valid_i = 1'b0;
        vec_cnt++; if (lru_hit_o !== 1'b1 || lru_miss_o !== 1'b0 || lru_way_o !== 1'b1) begin err_cnt++; $display("FAIL hit_lru got hit=%b miss=%b way=%b exp 1 0 1", lru_hit_o, lru_miss_o, lru_way_o); end
        vec_cnt++; if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0) begin err_cnt++; $display("FAIL hit_lookup_ready_resp got %b/%b exp 0/0", req_ready_o, resp_valid_o); end
        tick();                                 // cycle 3: RESP
        exp_hit = exp_hit + 16'd1;
        vec_cnt++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b1) begin err_cnt++; $display("FAIL hit_resp got valid=%b hit=%b exp 1 1", resp_valid_o, resp_hit_o); end
        vec_cnt++; if (hit_cnt_o !== exp_hit) begin err_cnt++; $display("FAIL hit_cnt got %0d exp %0d", hit_cnt_o, exp_hit); end
        vec_cnt++; if (lru_hit_o !== 1'b0) begin err_cnt++; $display("FAIL hit_lru_one_cycle got %b exp 0", lru_hit_o); end
        tick();                                 // IDLE
        vec_cnt++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL hit_return_idle got valid=%b ready=%b exp 0 1", resp_valid_o, req_ready_o); end
        lookup_hit_i = 1'b0; lookup_way_i = 1'b0;
        $display("hit: addr 0x1040 way 1");
    endtask

    task automatic test_clean_miss();
        int hs0;
        hs0 = hs_cnt;
        req_valid_i = 1'b1; req_addr_i = 32'h2044; lookup_hit_i = 1'b0;
        victim_way_i = 1'b0; victim_dirty_i = 1'b0; victim_addr_i = 32'hDEAD0000;
        mif.mem_req_ready_i = 1'b0;
        tick();                                 // LOOKUP
        req_valid_i = 1'b0;
        vec_cnt++; if (lru_miss_o !== 1'b1 || lru_hit_o !== 1'b0 || lru_way_o !== 1'b0) begin err_cnt++; $display("FAIL cmiss_lru got miss=%b hit=%b way=%b exp 1 0 0", lru_miss_o, lru_hit_o, lru_way_o); end
        tick();                                 // FILL_REQ
        exp_miss = exp_miss + 16'd1;
        vec_cnt++; if (mif.mem_req_valid_o !== 1'b1 || mif.mem_req_we_o !== 1'b0 || mif.mem_req_addr_o !== 32'h2040) begin err_cnt++; $display("FAIL cmiss_read_req got v=%b we=%b addr=%h exp 1 0 00002040", mif.mem_req_valid_o, mif.mem_req_we_o, mif.mem_req_addr_o); end
        vec_cnt++; if (miss_cnt_o !== exp_miss) begin err_cnt++; $display("FAIL cmiss_cnt got %0d exp %0d", miss_cnt_o, exp_miss); end
        mif.mem_req_ready_i = 1'b1;
        tick();                                 // FILL_WAIT
        mif.mem_req_ready_i = 1'b0;
        vec_cnt++; if (mif.mem_req_valid_o !== 1'b0 || fill_we_o !== 1'b0) begin err_cnt++; $display("FAIL cmiss_wait got valid=%b fill_we=%b exp 0 0", mif.mem_req_valid_o, fill_we_o); end
        mif.mem_rsp_valid_i = 1'b1; mif.mem_rsp_data_i = line_a;
        tick();                                 // RESP (cycle 5)
        mif.mem_rsp_valid_i = 1'b0; mif.mem_rsp_data_i = '0;
        vec_cnt++; if (fill_we_o !== 1'b1 || fill_way_o !== 1'b0 || fill_set_o !== 7'h01) begin err_cnt++; $display("FAIL cmiss_fill got we=%b way=%b set=%h exp 1 0 01", fill_we_o, fill_way_o, fill_set_o); end
        vec_cnt++; if (fill_line_o !== line_a) begin err_cnt++; $display("FAIL cmiss_fill_line got %h exp %h", fill_line_o, line_a); end
        vec_cnt++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b0) begin err_cnt++; $display("FAIL cmiss_resp got valid=%b hit=%b exp 1 0", resp_valid_o, resp_hit_o); end
        tick();                                 // IDLE
        vec_cnt++; if (fill_we_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL cmiss_idle got we=%b valid=%b ready=%b exp 0 0 1", fill_we_o, resp_valid_o, req_ready_o); end
        vec_cnt++; if (hs_cnt - hs0 !== 1 || hs_we !== 1'b0 || hs_addr !== 32'h2040) begin err_cnt++; $display("FAIL cmiss_mem_txn got n=%0d we=%b addr=%h exp 1 0 00002040", hs_cnt - hs0, hs_we, hs_addr); end
        $display("clean miss: addr 0x2044 -> read 0x2040, fill way 0 set 0x01");
    endtask

    task automatic test_dirty_miss();
        int hs0;
        hs0 = hs_cnt;
        req_valid_i = 1'b1; req_addr_i = 32'h3084; lookup_hit_i = 1'b0;
        victim_way_i = 1'b1; victim_dirty_i = 1'b1; victim_addr_i = 32'h8000; victim_line_i = line_b;
        mif.mem_req_ready_i = 1'b0;
        tick();                                 // LOOKUP
        req_valid_i = 1'b0;
        vec_cnt++; if (lru_miss_o !== 1'b1 || lru_way_o !== 1'b1) begin err_cnt++; $display("FAIL dmiss_lru got miss=%b way=%b exp 1 1", lru_miss_o, lru_way_o); end
        tick();                                 // WB_REQ
        exp_miss = exp_miss + 16'd1;
        // Victim inputs move away and a stray response arrives during the stall.
        victim_way_i = 1'b0; victim_dirty_i = 1'b0; victim_addr_i = 32'hFFFF0000; victim_line_i = ~line_b;
        mif.mem_rsp_valid_i = 1'b1; mif.mem_rsp_data_i = line_c;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (mif.mem_req_valid_o !== 1'b1 || mif.mem_req_we_o !== 1'b1 || mif.mem_req_addr_o !== 32'h8000) begin err_cnt++; $display("FAIL dmiss_wb_stall%0d got v=%b we=%b addr=%h exp 1 1 00008000", i, mif.mem_req_valid_o, mif.mem_req_we_o, mif.mem_req_addr_o); end
            vec_cnt++; if (mif.mem_wdata_o !== line_b) begin err_cnt++; $display("FAIL dmiss_wb_data%0d got %h exp %h", i, mif.mem_wdata_o, line_b); end
            vec_cnt++; if (fill_we_o !== 1'b0 || resp_valid_o !== 1'b0) begin err_cnt++; $display("FAIL dmiss_spurious%0d got we=%b valid=%b exp 0 0", i, fill_we_o, resp_valid_o); end
            tick();
        end
        vec_cnt++; if (mif.mem_req_we_o !== 1'b1 || mif.mem_req_addr_o !== 32'h8000) begin err_cnt++; $display("FAIL dmiss_wb_held got we=%b addr=%h exp 1 00008000", mif.mem_req_we_o, mif.mem_req_addr_o); end
        mif.mem_rsp_valid_i = 1'b0; mif.mem_req_ready_i = 1'b1;
        tick();                                 // FILL_REQ
        vec_cnt++; if (mif.mem_req_valid_o !== 1'b1 || mif.mem_req_we_o !== 1'b0 || mif.mem_req_addr_o !== 32'h3080) begin err_cnt++; $display("FAIL dmiss_read_req got v=%b we=%b addr=%h exp 1 0 00003080", mif.mem_req_valid_o, mif.mem_req_we_o, mif.mem_req_addr_o); end
        tick();                                 // FILL_WAIT
        mif.mem_req_ready_i = 1'b0;
        mif.mem_rsp_valid_i = 1'b1; mif.mem_rsp_data_i = line_c;
        tick();                                 // RESP
        mif.mem_rsp_valid_i = 1'b0; mif.mem_rsp_data_i = '0;
        vec_cnt++; if (fill_we_o !== 1'b1 || fill_way_o !== 1'b1 || fill_set_o !== 7'h42) begin err_cnt++; $display("FAIL dmiss_fill got we=%b way=%b set=%h exp 1 1 42", fill_we_o, fill_way_o, fill_set_o); end
        vec_cnt++; if (fill_line_o !== line_c) begin err_cnt++; $display("FAIL dmiss_fill_line got %h exp %h", fill_line_o, line_c); end
        vec_cnt++; if (resp_valid_o !== 1'b1 || resp_hit_o !== 1'b0 || miss_cnt_o !== exp_miss) begin err_cnt++; $display("FAIL dmiss_resp got valid=%b hit=%b miss=%0d exp 1 0 %0d", resp_valid_o, resp_hit_o, miss_cnt_o, exp_miss); end
        tick();                                 // IDLE
        vec_cnt++; if (hs_cnt - hs0 !== 2 || hs_we !== 1'b0 || hs_addr !== 32'h3080) begin err_cnt++; $display("FAIL dmiss_mem_txns got n=%0d last_we=%b last_addr=%h exp 2 0 00003080", hs_cnt - hs0, hs_we, hs_addr); end
        $display("dirty miss: writeback 0x8000 (3 stalls), read 0x3080, fill way 1 set 0x42");
    endtask

    task automatic test_spurious_idle();
        mif.mem_rsp_valid_i = 1'b1; mif.mem_rsp_data_i = line_a;
        tick(); tick();
        vec_cnt++; if (fill_we_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL idle_spurious got we=%b valid=%b ready=%b exp 0 0 1", fill_we_o, resp_valid_o, req_ready_o); end
        vec_cnt++; if (mif.mem_req_valid_o !== 1'b0 || miss_cnt_o !== exp_miss || hit_cnt_o !== exp_hit) begin err_cnt++; $display("FAIL idle_spurious_state got memv=%b miss=%0d hit=%0d exp 0 %0d %0d", mif.mem_req_valid_o, miss_cnt_o, hit_cnt_o, exp_miss, exp_hit); end
        mif.mem_rsp_valid_i = 1'b0; mif.mem_rsp_data_i = '0;
        $display("spurious response in IDLE: ignored");
    endtask

    task automatic test_back_to_back();
        req_valid_i = 1'b1; req_addr_i = 32'h0100; lookup_hit_i = 1'b1; lookup_way_i = 1'b0;
        tick();                                 // LOOKUP #1
        tick();                                 // RESP #1
        exp_hit = exp_hit + 16'd1;
        vec_cnt++; if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_resp1 got ready=%b valid=%b exp 0 1", req_ready_o, resp_valid_o); end
        tick();                                 // IDLE, accepts #2
        vec_cnt++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle got ready=%b valid=%b exp 1 0", req_ready_o, resp_valid_o); end
        tick();                                 // LOOKUP #2
        req_valid_i = 1'b0;
        vec_cnt++; if (lru_hit_o !== 1'b1 || lru_way_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_lookup2 got hit=%b way=%b exp 1 0", lru_hit_o, lru_way_o); end
        tick();                                 // RESP #2
        exp_hit = exp_hit + 16'd1;
        vec_cnt++; if (resp_valid_o !== 1'b1 || hit_cnt_o !== exp_hit) begin err_cnt++; $display("FAIL b2b_resp2 got valid=%b hits=%0d exp 1 %0d", resp_valid_o, hit_cnt_o, exp_hit); end
        tick();
        lookup_hit_i = 1'b0;
        $display("back-to-back: two hits, second accepted the cycle after RESP");
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_addr_i = 32'h5000; lookup_hit_i = 1'b0;
        victim_way_i = 1'b1; victim_dirty_i = 1'b0;
        mif.mem_req_ready_i = 1'b1;
        tick();                                 // LOOKUP
        req_valid_i = 1'b0;
        tick();                                 // FILL_REQ
        tick();                                 // FILL_WAIT
        mif.mem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        exp_hit = 16'd0; exp_miss = 16'd0;
        vec_cnt++; if (req_ready_o !== 1'b1 || mif.mem_req_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_state got ready=%b memv=%b valid=%b exp 1 0 0", req_ready_o, mif.mem_req_valid_o, resp_valid_o); end
        vec_cnt++; if (hit_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin err_cnt++; $display("FAIL rstmid_counters got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o); end
        tick();
        rst_i = 1'b0;
        mif.mem_rsp_valid_i = 1'b1; mif.mem_rsp_data_i = line_a;
        tick();
        vec_cnt++; if (fill_we_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin err_cnt++; $display("FAIL rstmid_late_rsp got we=%b valid=%b ready=%b exp 0 0 1", fill_we_o, resp_valid_o, req_ready_o); end
        mif.mem_rsp_valid_i = 1'b0; mif.mem_rsp_data_i = '0;
        $display("reset during FILL_WAIT: abandoned, late response ignored");
    endtask

    task automatic test_saturation();
        // Preload close to the limit instead of replaying 65k hits.
        force dut.hit_cnt_reg = 16'hFFFD;
        #1;
        release dut.hit_cnt_reg;
        exp_hit = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1; req_addr_i = 32'h1040; lookup_hit_i = 1'b1; lookup_way_i = 1'b1;
            tick();                             // LOOKUP
            req_valid_i = 1'b0;
            tick();                             // RESP
            if (exp_hit != 16'hFFFF) exp_hit = exp_hit + 16'd1;
            vec_cnt++; if (hit_cnt_o !== exp_hit) begin err_cnt++; $display("FAIL sat_hit%0d got %h exp %h", i, hit_cnt_o, exp_hit); end
            tick();                             // IDLE
        end
        lookup_hit_i = 1'b0;
        force dut.miss_cnt_reg = 16'hFFFE;
        #1;
        release dut.miss_cnt_reg;
        exp_miss = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            run_clean_miss(32'h6000);
            if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
            vec_cnt++; if (miss_cnt_o !== exp_miss) begin err_cnt++; $display("FAIL sat_miss%0d got %h exp %h", i, miss_cnt_o, exp_miss); end
        end
        $display("saturation: hit and miss counters hold at 0xFFFF");
    endtask

    initial begin
        line_a = {16{32'hA5A5_0001}};
        line_b = {16{32'hB00B_1E55}};
        line_c = {8{64'h0123_4567_89AB_CDEF}};
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_spurious_idle();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
